// File: rtl/shift_link_pkg.sv
// Frame-format constants and receiver state encoding shared by both ends of
// the calculator's serial shift link.
package shift_link_pkg;

  // Default frame format; transmitter and receiver must agree on both.
  localparam int unsigned LINK_WIDTH        = 32;
  localparam int unsigned LINK_CLKS_PER_BIT = 16;

  // Receiver FSM states.
  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_ALIGN  = 2'd1,
    RX_SAMPLE = 2'd2,
    RX_DONE   = 2'd3
  } rx_state_e;

endpackage

// File: rtl/shift_rx_deser_sync_ff.sv
// Multi-flop synchroniser for one asynchronous input bit.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through STAGES flops; cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/shift_rx_deser.sv
// Serial-to-parallel receiver for the calculator shift link: samples an
// LSB-first stream framed by frame_in at mid-bit, rebuilds a WIDTH-bit word and
// offers it on a valid/ready handshake. Reports aborted frames and dropped words.
module shift_rx_deser
  import shift_link_pkg::*;
#(
  parameter int unsigned WIDTH        = LINK_WIDTH,
  parameter int unsigned CLKS_PER_BIT = LINK_CLKS_PER_BIT,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             frame_in,
  input  logic             out_ready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] Dout,
  output logic             out_valid,
  output logic             rx_busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(WIDTH + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] WORD_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0] FIRST_BIT = BW'(1);

  logic             s_data;
  logic             s_frame;
  logic             s_frame_q;
  rx_state_e        state;
  logic [CW-1:0]    clk_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] word;
  logic             abort;
  logic             deliver_ok;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_data (
    .clk   (clk),
    .reset (reset),
    .d     (serial_in),
    .q     (s_data)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_frame (
    .clk   (clk),
    .reset (reset),
    .d     (frame_in),
    .q     (s_frame)
  );

  // Frame loss while a frame is in progress aborts it.
  always_comb begin
    abort = 1'b0;
    if (((state == RX_ALIGN) || (state == RX_SAMPLE)) && !s_frame) begin
      abort = 1'b1;
    end
  end

  // A finished word can be taken if the output slot is empty or draining now.
  assign deliver_ok = !out_valid || out_ready;

  assign rx_busy = (state == RX_ALIGN) || (state == RX_SAMPLE);

  // Frame FSM: detect frame start, align to mid-bit, shift bits in LSB first.
  // Bits enter at the MSB end so that after WIDTH shifts bit 0 sits at [0].
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= RX_IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      word      <= '0;
      s_frame_q <= 1'b0;
    end else begin
      s_frame_q <= s_frame;
      case (state)
        RX_IDLE: begin
          if (s_frame && !s_frame_q) begin
            state   <= RX_ALIGN;
            clk_cnt <= '0;
            bit_cnt <= '0;
            word    <= '0;
          end
        end
        RX_ALIGN: begin
          if (!s_frame) begin
            state <= RX_IDLE;
          end else if (clk_cnt == HALF_LAST) begin
            word    <= {s_data, word[WIDTH-1:1]};
            bit_cnt <= FIRST_BIT;
            clk_cnt <= '0;
            state   <= RX_SAMPLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_SAMPLE: begin
          if (!s_frame) begin
            state <= RX_IDLE;
          end else if (clk_cnt == BIT_LAST) begin
            word    <= {s_data, word[WIDTH-1:1]};
            clk_cnt <= '0;
            if (bit_cnt == WORD_LAST) begin
              state <= RX_DONE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_DONE: begin
          state <= RX_IDLE;
        end
        default: begin
          state <= RX_IDLE;
        end
      endcase
    end
  end

  // Output slot: load on delivery (wins over a same-cycle accept), clear on
  // accept, drop into the sticky overrun flag when the slot is still occupied.
  always_ff @(posedge clk) begin
    if (!reset) begin
      Dout      <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= abort;
      if ((state == RX_DONE) && deliver_ok) begin
        Dout      <= word;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if ((state == RX_DONE) && !deliver_ok) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_rx_deser.sv
// Self-checking bench for shift_rx_deser: serial frames are driven LSB first,
// expected words are queued at send time and compared at each handshake.
module tb_shift_rx_deser;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CLKS  = 16;
  localparam int unsigned SYNC  = 2;
  // Edges from the frame's first drive edge to the edge closing the DONE cycle.
  localparam int unsigned DONE_EDGE = SYNC + 2 + CLKS / 2 + CLKS * (WIDTH - 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             serial_in;
  logic             frame_in;
  logic             out_ready;
  logic             ovr_clr;
  logic [WIDTH-1:0] Dout;
  logic             out_valid;
  logic             rx_busy;
  logic             frame_err;
  logic             overrun;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned err_cycles = 0;
  int unsigned valid_cycles = 0;
  int unsigned ovr_cycles = 0;
  logic [WIDTH-1:0] sb[$];

  shift_rx_deser #(
    .WIDTH        (WIDTH),
    .CLKS_PER_BIT (CLKS),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .serial_in (serial_in),
    .frame_in  (frame_in),
    .out_ready (out_ready),
    .ovr_clr   (ovr_clr),
    .Dout      (Dout),
    .out_valid (out_valid),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Handshake monitor and event counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      if (frame_err) err_cycles++;
      if (out_valid) valid_cycles++;
      if (overrun)   ovr_cycles++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_word", sb.size(), 1);
        end else begin
          check("dout_word", Dout, sb.pop_front());
        end
      end
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w, input int unsigned nbits,
                            input int glitch_bit);
    @(posedge clk);
    #2;
    frame_in = 1'b1;
    for (int b = 0; b < int'(nbits); b++) begin
      for (int c = 0; c < int'(CLKS); c++) begin
        serial_in = w[b] ^ ((b == glitch_bit) && (c >= 1) && (c <= 3));
        @(posedge clk);
        #2;
      end
    end
    frame_in  = 1'b0;
    serial_in = 1'b0;
  endtask

  task automatic wait_drain(input int unsigned limit);
    for (int i = 0; (i < int'(limit)) && (sb.size() != 0); i++) @(posedge clk);
    #2;
    check("drain", sb.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned e0, v0, o0, n;

    reset = 1'b0; serial_in = 1'b0; frame_in = 1'b0;
    out_ready = 1'b0; ovr_clr = 1'b0;
    idle(5);
    check("rst_dout", Dout, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    reset = 1'b1;
    idle(4);

    // Single frame with consumer always ready.
    out_ready = 1'b1;
    e0 = err_cycles; v0 = valid_cycles; o0 = ovr_cycles;
    sb.push_back(32'hA5A5_1234);
    send_frame(32'hA5A5_1234, WIDTH, -1);
    wait_drain(100);
    idle(2 * CLKS);
    check("t1_valid_cycles", valid_cycles - v0, 1);
    check("t1_ferr_cycles", err_cycles - e0, 0);
    check("t1_ovr_cycles", ovr_cycles - o0, 0);

    // Stalled consumer: first word held, second dropped, overrun cleared.
    out_ready = 1'b0;
    sb.push_back(32'hFFFF_FFFF);
    send_frame(32'hFFFF_FFFF, WIDTH, -1);
    idle(2 * CLKS);
    check("t2_hold_valid", out_valid, 1);
    check("t2_hold_dout", Dout, 32'hFFFF_FFFF);
    check("t2_ovr_before", overrun, 0);
    send_frame(32'h0000_0001, WIDTH, -1);
    idle(2 * CLKS);
    check("t2_ovr_set", overrun, 1);
    check("t2_dout_kept", Dout, 32'hFFFF_FFFF);
    check("t2_valid_kept", out_valid, 1);
    ovr_clr = 1'b1;
    idle(1);
    ovr_clr = 1'b0;
    check("t2_ovr_clr", overrun, 0);
    out_ready = 1'b1;
    wait_drain(20);
    idle(2);
    check("t2_valid_fall", out_valid, 0);

    // Frame cut short after 10 bits, then a clean frame.
    e0 = err_cycles; v0 = valid_cycles;
    send_frame(32'h1357_9BDF, 10, -1);
    n = 0;
    while (rx_busy && (n < SYNC + 1)) begin
      @(posedge clk);
      n++;
      #1;
    end
    check("t3_busy_drop", rx_busy, 0);
    idle(2 * CLKS);
    check("t3_ferr_pulses", err_cycles - e0, 1);
    check("t3_no_valid", valid_cycles - v0, 0);
    check("t3_valid_low", out_valid, 0);
    sb.push_back(32'h0F0F_0F0F);
    send_frame(32'h0F0F_0F0F, WIDTH, -1);
    wait_drain(100);
    idle(2 * CLKS);

    // Second word completes on the very cycle the first is accepted.
    out_ready = 1'b0;
    sb.push_back(32'h1111_2222);
    send_frame(32'h1111_2222, WIDTH, -1);
    idle(2 * CLKS);
    check("t4_first_valid", out_valid, 1);
    sb.push_back(32'h3333_4444);
    fork
      send_frame(32'h3333_4444, WIDTH, -1);
      begin
        repeat (DONE_EDGE) @(posedge clk);
        #2;
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        out_ready = 1'b0;
      end
    join
    idle(2);
    check("t4_valid_kept", out_valid, 1);
    check("t4_dout_second", Dout, 32'h3333_4444);
    check("t4_no_ovr", overrun, 0);
    check("t4_sb_one", sb.size(), 1);
    out_ready = 1'b1;
    wait_drain(20);
    idle(2 * CLKS);

    // Reset in the middle of bit 20 of a frame.
    e0 = err_cycles; v0 = valid_cycles;
    fork
      send_frame(32'h1234_5678, 21, -1);
      begin
        repeat (20 * CLKS + 4) @(posedge clk);
        #2;
        reset = 1'b0;
      end
    join
    idle(4);
    check("t5_dout", Dout, 0);
    check("t5_valid", out_valid, 0);
    check("t5_busy", rx_busy, 0);
    check("t5_ferr", frame_err, 0);
    check("t5_ovr", overrun, 0);
    reset = 1'b1;
    idle(3 * CLKS);
    check("t5_no_ferr", err_cycles - e0, 0);
    check("t5_no_valid", valid_cycles - v0, 0);
    sb.push_back(32'hDEAD_BEEF);
    send_frame(32'hDEAD_BEEF, WIDTH, -1);
    wait_drain(100);
    idle(2 * CLKS);

    // Off-centre glitch on bit 5 must not be sampled.
    sb.push_back(32'h0000_0000);
    send_frame(32'h0000_0000, WIDTH, 5);
    wait_drain(100);
    idle(2 * CLKS);
    check("final_ovr", overrun, 0);
    check("final_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
